// File: rtl/aes_round_ctrl_pkg.sv
// Shared types for the AES round sequencer: FSM states, stage indices and the SRAM request bundle.
// Imported by aes_round_ctrl and sram_port_mux.
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SB   = 3'd1,
    SR   = 3'd2,
    MC   = 3'd3,
    ARK  = 3'd4,
    DONE = 3'd5
  } round_state_t;

  localparam int STG_SB     = 0;
  localparam int STG_SR     = 1;
  localparam int STG_MC     = 2;
  localparam int STG_ARK    = 3;
  localparam int NUM_STAGES = 4;

  typedef struct packed {
    logic         read;
    logic         write;
    logic         dump;
    logic         init;
    logic [15:0]  addr;
    logic [127:0] wdata;
    logic [2:0]   dumpNum;
    logic [2:0]   initNum;
  } sram_bundle_t;

  function automatic logic isRunState(input round_state_t s);
    return (s == SB) || (s == SR) || (s == MC) || (s == ARK);
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Handshake and SRAM bus between the round sequencer and its four round stages.
// slave is the sequencer's view; master is the view of the stages and host.
interface aes_round_ctrl_if;

  logic              start;
  logic              busy;
  logic              done;
  logic              error;
  logic [3:0]        round;

  logic [3:0]        stage_enable;
  logic [3:0]        stage_finished;

  logic [3:0]        stage_sramRead;
  logic [3:0]        stage_sramWrite;
  logic [3:0]        stage_sramDump;
  logic [3:0]        stage_sramInit;
  logic [3:0][15:0]  stage_sramAddr;
  logic [3:0][127:0] stage_sramWriteValue;
  logic [3:0][2:0]   stage_sramDumpNum;
  logic [3:0][2:0]   stage_sramInitNum;

  logic              sramRead;
  logic              sramWrite;
  logic              sramDump;
  logic              sramInit;
  logic [15:0]       sramAddr;
  logic [127:0]      sramWriteValue;
  logic [2:0]        sramDumpNum;
  logic [2:0]        sramInitNum;

  modport master (
    output start, stage_finished,
    output stage_sramRead, stage_sramWrite, stage_sramDump, stage_sramInit,
    output stage_sramAddr, stage_sramWriteValue, stage_sramDumpNum, stage_sramInitNum,
    input  busy, done, error, round, stage_enable,
    input  sramRead, sramWrite, sramDump, sramInit,
    input  sramAddr, sramWriteValue, sramDumpNum, sramInitNum
  );

  modport slave (
    input  start, stage_finished,
    input  stage_sramRead, stage_sramWrite, stage_sramDump, stage_sramInit,
    input  stage_sramAddr, stage_sramWriteValue, stage_sramDumpNum, stage_sramInitNum,
    output busy, done, error, round, stage_enable,
    output sramRead, sramWrite, sramDump, sramInit,
    output sramAddr, sramWriteValue, sramDumpNum, sramInitNum
  );

endinterface

// File: rtl/aes_round_ctrl_sram_port_mux.sv
// 4:1 SRAM request bundle mux with one-hot select; an all-zero select yields an all-zero bundle.
module sram_port_mux
  import aes_pkg::*;
(
  input  logic [NUM_STAGES-1:0]         sel,
  input  sram_bundle_t [NUM_STAGES-1:0] bundleIn,
  output sram_bundle_t                  bundleOut
);

  localparam int BW = $bits(sram_bundle_t);

  logic [NUM_STAGES-1:0][BW-1:0] masked;
  logic [BW-1:0]                 orAcc;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : gMask
      assign masked[gi] = sel[gi] ? BW'(bundleIn[gi]) : '0;
    end
  endgenerate

  // AND-OR structure: relies on the select being one-hot or zero.
  always_comb begin
    orAcc = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      orAcc = orAcc | masked[i];
    end
  end

  assign bundleOut = sram_bundle_t'(orAcc);

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: walks SB/SR/MC/ARK stages through rounds 0..NR and muxes the active stage onto the SRAM port.
// Optional per-stage watchdog compiled in with AES_ROUND_CTRL_WDOG_EN.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR          = 10,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             n_rst,
  aes_round_ctrl_if.slave  bus
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  round_state_t stateReg, stateNext;
  logic [3:0]   roundReg, roundNext;
  logic [3:0]   stageEnable;
  logic         activeFinished;
  logic         timeout;

  sram_bundle_t [NUM_STAGES-1:0] stageBundle;
  sram_bundle_t                  portBundle;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stateReg <= IDLE;
      roundReg <= '0;
    end else begin
      stateReg <= stateNext;
      roundReg <= roundNext;
    end
  end

  always_comb begin
    stageEnable = '0;
    case (stateReg)
      SB:      stageEnable[STG_SB]  = 1'b1;
      SR:      stageEnable[STG_SR]  = 1'b1;
      MC:      stageEnable[STG_MC]  = 1'b1;
      ARK:     stageEnable[STG_ARK] = 1'b1;
      default: stageEnable = '0;
    endcase
  end

  // Masking with the enable makes every non-active finished bit irrelevant.
  assign activeFinished = |(stageEnable & bus.stage_finished);

  always_comb begin
    stateNext = stateReg;
    roundNext = roundReg;
    case (stateReg)
      IDLE: begin
        if (bus.start) begin
          stateNext = ARK;
          roundNext = '0;
        end
      end
      SB: begin
        if (activeFinished) stateNext = SR;
      end
      SR: begin
        if (activeFinished) stateNext = (roundReg == LAST_ROUND) ? ARK : MC;
      end
      MC: begin
        if (activeFinished) stateNext = ARK;
      end
      ARK: begin
        if (activeFinished) begin
          if (roundReg == LAST_ROUND) begin
            stateNext = DONE;
          end else begin
            stateNext = SB;
            roundNext = roundReg + 4'd1;
          end
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (timeout) begin
      stateNext = IDLE;
      roundNext = '0;
    end
  end

`ifdef AES_ROUND_CTRL_WDOG_EN
  logic [15:0] wdogCnt;
  logic        errorReg;
  logic        runState;

  assign runState = isRunState(stateReg);
  assign timeout  = runState && !activeFinished && (wdogCnt == 16'(WDOG_CYCLES - 1));

  // Counter restarts on every state change so each stage gets a full budget.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wdogCnt  <= '0;
      errorReg <= 1'b0;
    end else begin
      errorReg <= timeout;
      if (stateNext != stateReg) begin
        wdogCnt <= '0;
      end else if (runState) begin
        wdogCnt <= wdogCnt + 16'd1;
      end
    end
  end

  assign bus.error = errorReg;
`else
  assign timeout   = 1'b0;
  assign bus.error = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : gPack
      assign stageBundle[gi].read    = bus.stage_sramRead[gi];
      assign stageBundle[gi].write   = bus.stage_sramWrite[gi];
      assign stageBundle[gi].dump    = bus.stage_sramDump[gi];
      assign stageBundle[gi].init    = bus.stage_sramInit[gi];
      assign stageBundle[gi].addr    = bus.stage_sramAddr[gi];
      assign stageBundle[gi].wdata   = bus.stage_sramWriteValue[gi];
      assign stageBundle[gi].dumpNum = bus.stage_sramDumpNum[gi];
      assign stageBundle[gi].initNum = bus.stage_sramInitNum[gi];
    end
  endgenerate

  sram_port_mux uMux (
    .sel       (stageEnable),
    .bundleIn  (stageBundle),
    .bundleOut (portBundle)
  );

  assign bus.sramRead       = portBundle.read;
  assign bus.sramWrite      = portBundle.write;
  assign bus.sramDump       = portBundle.dump;
  assign bus.sramInit       = portBundle.init;
  assign bus.sramAddr       = portBundle.addr;
  assign bus.sramWriteValue = portBundle.wdata;
  assign bus.sramDumpNum    = portBundle.dumpNum;
  assign bus.sramInitNum    = portBundle.initNum;

  assign bus.busy         = (stateReg != IDLE);
  assign bus.done         = (stateReg == DONE);
  assign bus.round        = roundReg;
  assign bus.stage_enable = stageEnable;

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Round sequencer and SRAM port arbiter for the AES encryption datapath. On `start` it walks the four round-stage blocks through the AES-128 schedule: sub-bytes, shift-rows, mix-columns and add-round-key. It uses each stage's enable/finished handshake. It forwards only the active stage's SRAM request bundle onto the single shared SRAM port. `sramReadValue` is fanned out to all stages at the top level and does not pass through this block.

## Interface
- `NR`, 10: number of AES rounds (round indices 0..NR).
- `WDOG_CYCLES`, 1024: per-stage timeout, used only when the watchdog is compiled in.
- `clk` in 1: clock, rising edge.
- `n_rst` in 1: reset, asynchronous, active-low.
- `start` in 1: begin one block encryption; sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the final add-round-key finishes.
- `error` out 1: one-cycle pulse on watchdog timeout; tied 0 without the macro.
- `round` out 4: current round index; also the round-key select.
- `stage_enable` out 4: bit 0 sub-bytes, 1 shift-rows, 2 mix-columns, 3 add-round-key.
- `stage_finished` in 4: finished pulses from the stages, same bit order.
- `stage_sramRead`, `stage_sramWrite`, `stage_sramDump`, `stage_sramInit` in 4 each: per-stage requests.
- `stage_sramAddr` in 4x16: per-stage address.
- `stage_sramWriteValue` in 4x128: per-stage write data.
- `stage_sramDumpNum`, `stage_sramInitNum` in 4x3: per-stage dump/init counts.
- `sramRead`, `sramWrite`, `sramDump`, `sramInit` out 1: shared SRAM port controls.
- `sramAddr` out 16: shared SRAM address.
- `sramWriteValue` out 128: shared SRAM write data.
- `sramDumpNum`, `sramInitNum` out 3: shared SRAM dump/init counts.

## Operation
- States: IDLE, SB, SR, MC, ARK, DONE.
- Reset forces the following, regardless of any operation in flight:
  - state IDLE, `round`=0;
  - all enables, `busy`, `done`, `error` 0;
  - all SRAM outputs 0.
- IDLE: `start`=1 moves to ARK with `round`=0.
- Round 0: ARK only.
- Rounds 1..NR-1: SB, SR, MC, ARK.
- Round NR: SB, SR, ARK; MC is skipped.
- ARK finishing with `round`<NR increments `round` and moves to SB.
- ARK finishing with `round`=NR moves to DONE.
- DONE lasts one cycle with `done`=1, then returns to IDLE. `round` holds NR until the next `start`.
- In each RUN state (SB, SR, MC, ARK):
  - exactly one `stage_enable` bit is high, held level until that stage's `finished` is sampled;
  - only the active stage's `stage_finished` bit is honoured; the other bits are ignored.
- `start` while busy is ignored.
- Arbitration: a combinational mux selected by the registered state forwards the active stage's complete SRAM bundle. Inactive bundles are discarded. In IDLE and DONE all SRAM outputs are 0.

## Timing
- `start` high at edge t: `stage_enable[3]`=1 and `busy`=1 from t+1.
- Active stage's finished high at edge t:
  - the old enable is 0 from t+1;
  - the next enable is 1 from t+1 (same-edge handover, no gap cycle);
  - the SRAM mux switches at t+1.
- SRAM path latency is 0 cycles: requests pass combinationally within the cycle.
- Total latency with every stage taking F cycles from enable to finished: 1 + (4·(NR-1)+4)·F cycles from `start` to `done`.
- `finished` asserted in the same cycle the enable rises is legal and honoured.

## Configuration
- `AES_ROUND_CTRL_WDOG_EN` defined:
  - a 16-bit counter clears on every state entry and increments each cycle in a RUN state;
  - reaching WDOG_CYCLES with no finished pulses `error` for one cycle, drops all enables and returns to IDLE (`round` reset to 0).
- Macro undefined: no counter, `error` tied 0, a stage may stall indefinitely.

## Structure
- Package `aes_pkg` holds:
  - state enum `round_state_t`;
  - stage index constants `STG_SB`=0, `STG_SR`=1, `STG_MC`=2, `STG_ARK`=3;
  - the SRAM bundle struct (read, write, dump, init, addr, wdata, dumpNum, initNum).
- One sub-module, `sram_port_mux`: 4:1 bundle mux with a one-hot select and an all-zero default.

## Test plan
- Reset: `n_rst` low with `start`=1 → all outputs 0; first `start` after release gives `stage_enable`=4'b1000 at the next cycle.
- Full run: NR=10, stage models with F=3 → enable sequence ARK, then (SB,SR,MC,ARK)x9, then SB,SR,ARK; `done` at cycle 1+40·3=121; `round` ends at 10.
- Arbitration: the SR bundle drives addr 16'd32 read; an inactive stage drives addr 16'hFFFF write → port shows addr 32, `sramRead`=1, `sramWrite`=0 only while SR is active.
- Spurious finished: `stage_finished`=4'b0100 during SB, and `start` pulsed mid-run → no state change, `round` unchanged.
- Reset mid-run: `n_rst` low during round 5 MC → immediate IDLE, enables 0, `round`=0.
- Watchdog (macro defined, WDOG_CYCLES=16): SR never finishes → `error` pulse 16 cycles after SR entry, then IDLE.
